// File: rtl/acl_frame_fwd_ctrl.sv
`default_nettype none
//==============================================================================
// Module : acl_frame_fwd_ctrl
// Desc   : Ingress FIFO read controller. It buffers the 4-word header, requests an
//          ACL verdict, then forwards the frame or flushes it. Define ACL_STATS_EN
//          to enable the fwd/drop/runt statistics counters.
// Rev    : 1.0
//==============================================================================
module acl_frame_fwd_ctrl #(
  parameter int VERDICT_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_fifo_data,
  input  logic        i_fifo_last,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd,
  output logic        o_acl_req,
  output logic [47:0] o_acl_dest_mac,
  output logic [47:0] o_acl_src_mac,
  output logic [15:0] o_acl_ethertype,
  input  logic        i_acl_valid,
  input  logic        i_acl_permit,
  output logic [31:0] o_tx_tdata,
  output logic        o_tx_tvalid,
  output logic        o_tx_tlast,
  input  logic        i_tx_tready,
  output logic [31:0] o_fwd_count,
  output logic [31:0] o_drop_count,
  output logic [31:0] o_runt_count
);

  localparam int c_TW = $clog2(VERDICT_TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(VERDICT_TIMEOUT - 1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_HDR      = 3'd1;
  localparam logic [2:0] c_ST_REQ      = 3'd2;
  localparam logic [2:0] c_ST_FWD_HDR  = 3'd3;
  localparam logic [2:0] c_ST_FWD_BODY = 3'd4;
  localparam logic [2:0] c_ST_DROP     = 3'd5;

  logic [2:0]      r_state;
  logic [1:0]      r_idx;
  logic [c_TW-1:0] r_tmo;
  logic            r_hdr_last;
  logic [31:0]     r_hbuf [4];

  logic w_permit;
  logic w_deny;

  // A strobe in the expiry cycle takes precedence over the timeout.
  assign w_permit = (r_state == c_ST_REQ) && i_acl_valid && i_acl_permit;
  assign w_deny   = (r_state == c_ST_REQ) &&
                    ((i_acl_valid && !i_acl_permit) || (!i_acl_valid && (r_tmo == c_TMO_LAST)));

  assign o_acl_req       = (r_state == c_ST_REQ);
  assign o_acl_dest_mac  = {r_hbuf[0], r_hbuf[1][31:16]};
  assign o_acl_src_mac   = {r_hbuf[1][15:0], r_hbuf[2]};
  assign o_acl_ethertype = r_hbuf[3][31:16];

  always_comb begin
    o_fifo_rd   = 1'b0;
    o_tx_tvalid = 1'b0;
    o_tx_tlast  = 1'b0;
    o_tx_tdata  = 32'h0;
    case (r_state)
      c_ST_HDR: o_fifo_rd = !i_fifo_empty;
      c_ST_FWD_HDR: begin
        o_tx_tvalid = 1'b1;
        o_tx_tdata  = r_hbuf[r_idx];
        o_tx_tlast  = (r_idx == 2'd3) && r_hdr_last;
      end
      c_ST_FWD_BODY: begin
        o_tx_tvalid = !i_fifo_empty;
        o_tx_tdata  = i_fifo_data;
        o_tx_tlast  = i_fifo_last && !i_fifo_empty;
        o_fifo_rd   = !i_fifo_empty && i_tx_tready;
      end
      c_ST_DROP: o_fifo_rd = !i_fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_idx      <= 2'd0;
      r_tmo      <= '0;
      r_hdr_last <= 1'b0;
      for (int i = 0; i < 4; i++) r_hbuf[i] <= 32'h0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_idx <= 2'd0;
          if (!i_fifo_empty) r_state <= c_ST_HDR;
        end
        c_ST_HDR: begin
          if (!i_fifo_empty) begin
            r_hbuf[r_idx] <= i_fifo_data;
            if (r_idx == 2'd3) begin
              r_state    <= c_ST_REQ;
              r_hdr_last <= i_fifo_last;
              r_idx      <= 2'd0;
              r_tmo      <= '0;
            end else if (i_fifo_last) begin
              r_state <= c_ST_IDLE;
              r_idx   <= 2'd0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        c_ST_REQ: begin
          r_tmo <= r_tmo + c_TW'(1);
          if (w_permit)    r_state <= c_ST_FWD_HDR;
          else if (w_deny) r_state <= r_hdr_last ? c_ST_IDLE : c_ST_DROP;
        end
        c_ST_FWD_HDR: begin
          if (i_tx_tready) begin
            if (r_idx == 2'd3) begin
              r_idx   <= 2'd0;
              r_state <= r_hdr_last ? c_ST_IDLE : c_ST_FWD_BODY;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        c_ST_FWD_BODY: begin
          if (!i_fifo_empty && i_tx_tready && i_fifo_last) r_state <= c_ST_IDLE;
        end
        c_ST_DROP: begin
          if (!i_fifo_empty && i_fifo_last) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef ACL_STATS_EN
  logic        w_fwd_evt;
  logic        w_drop_evt;
  logic        w_runt_evt;
  logic [31:0] r_fwd_count;
  logic [31:0] r_drop_count;
  logic [31:0] r_runt_count;

  // A 4-word frame completes in FWD_HDR; longer frames complete in FWD_BODY.
  assign w_fwd_evt  = ((r_state == c_ST_FWD_HDR) && i_tx_tready && (r_idx == 2'd3) && r_hdr_last) ||
                      ((r_state == c_ST_FWD_BODY) && !i_fifo_empty && i_tx_tready && i_fifo_last);
  assign w_drop_evt = (w_deny && r_hdr_last) ||
                      ((r_state == c_ST_DROP) && !i_fifo_empty && i_fifo_last);
  assign w_runt_evt = (r_state == c_ST_HDR) && !i_fifo_empty && i_fifo_last && (r_idx != 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fwd_count  <= 32'h0;
      r_drop_count <= 32'h0;
      r_runt_count <= 32'h0;
    end else begin
      if (w_fwd_evt && (r_fwd_count != 32'hFFFF_FFFF))   r_fwd_count  <= r_fwd_count + 32'd1;
      if (w_drop_evt && (r_drop_count != 32'hFFFF_FFFF)) r_drop_count <= r_drop_count + 32'd1;
      if (w_runt_evt && (r_runt_count != 32'hFFFF_FFFF)) r_runt_count <= r_runt_count + 32'd1;
    end
  end

  assign o_fwd_count  = r_fwd_count;
  assign o_drop_count = r_drop_count;
  assign o_runt_count = r_runt_count;
`else
  assign o_fwd_count  = 32'h0;
  assign o_drop_count = 32'h0;
  assign o_runt_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acl_frame_fwd_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_acl_frame_fwd_ctrl
// Desc   : Table-driven frame scenarios plus reset and back-to-back sequences.
// Rev    : 1.0
//==============================================================================
module tb_acl_frame_fwd_ctrl;

  localparam int VT = 8;
`ifdef ACL_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif
  localparam logic [47:0] c_DA   = 48'h0014_2201_2345;
  localparam logic [47:0] c_SA   = 48'h0014_2267_89AB;
  localparam logic [15:0] c_TYPE = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_fifo_data;
  logic        i_fifo_last;
  logic        i_fifo_empty;
  logic        o_fifo_rd;
  logic        o_acl_req;
  logic [47:0] o_acl_dest_mac;
  logic [47:0] o_acl_src_mac;
  logic [15:0] o_acl_ethertype;
  logic        i_acl_valid;
  logic        i_acl_permit;
  logic [31:0] o_tx_tdata;
  logic        o_tx_tvalid;
  logic        o_tx_tlast;
  logic        i_tx_tready;
  logic [31:0] o_fwd_count;
  logic [31:0] o_drop_count;
  logic [31:0] o_runt_count;

  always #5 clk = ~clk;

  acl_frame_fwd_ctrl #(.VERDICT_TIMEOUT(VT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_fifo_data(i_fifo_data), .i_fifo_last(i_fifo_last), .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd(o_fifo_rd), .o_acl_req(o_acl_req),
    .o_acl_dest_mac(o_acl_dest_mac), .o_acl_src_mac(o_acl_src_mac),
    .o_acl_ethertype(o_acl_ethertype),
    .i_acl_valid(i_acl_valid), .i_acl_permit(i_acl_permit),
    .o_tx_tdata(o_tx_tdata), .o_tx_tvalid(o_tx_tvalid), .o_tx_tlast(o_tx_tlast),
    .i_tx_tready(i_tx_tready),
    .o_fwd_count(o_fwd_count), .o_drop_count(o_drop_count), .o_runt_count(o_runt_count)
  );

  typedef struct {
    int nwords;
    int verdict;   // 0 deny, 1 permit, 2 never answer
    int delay;
    bit toggle;
    bit gaps;
    int exp_out;
    int exp_req;
    int d_fwd;
    int d_drop;
    int d_runt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [32:0] fifo_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] out_q[$];
  logic        gap = 1'b0;

  // stimulus modes
  int verdict_mode, verdict_delay;
  bit toggle_en, gap_en;

  // per-run observations
  int cycle = 0;
  int req_cycles, req_run, strobe_cycle, first_tv, tlast_cnt, tlast_idx;
  int first_tlast_cycle, first_pop_after, pops, viol, acl_unstable;
  bit sent, prev_stall;
  logic [31:0]  prev_data;
  logic [111:0] acl_seen;
  int exp_fwd = 0, exp_drop = 0, exp_runt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fifo_q.size() == 0) begin
      i_fifo_empty = 1'b1;
      i_fifo_data  = 32'h0;
      i_fifo_last  = 1'b0;
    end else begin
      i_fifo_empty = gap;
      i_fifo_data  = fifo_q[0][31:0];
      i_fifo_last  = fifo_q[0][32];
    end
  endtask

  task automatic push_frame(input int n, input int seed);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       w = c_DA[47:16];
        1:       w = {c_DA[15:0], c_SA[47:32]};
        2:       w = c_SA[31:0];
        3:       w = {c_TYPE, 16'h4500};
        default: w = {8'(seed), 8'(i >> 8), 8'(i), 8'hA5 ^ 8'(seed)};
      endcase
      fifo_q.push_back({(i == n - 1), w});
      exp_w.push_back(w);
    end
    drive_fifo();
  endtask

  task automatic clear_obs();
    out_q.delete(); exp_w.delete();
    req_cycles = 0; req_run = 0; strobe_cycle = -1; first_tv = -1;
    tlast_cnt = 0; tlast_idx = -1; first_tlast_cycle = -1; first_pop_after = -1;
    pops = 0; viol = 0; acl_unstable = 0; sent = 1'b0; prev_stall = 1'b0;
    prev_data = 32'h0; acl_seen = '0;
  endtask

  // One clock: observe at the falling edge, update inputs just after the rising edge.
  task automatic step();
    bit do_pop;
    bit obs_req;
    @(negedge clk);
    cycle++;
    obs_req = o_acl_req;
    if (o_acl_req) begin
      if (req_cycles == 0) acl_seen = {o_acl_dest_mac, o_acl_src_mac, o_acl_ethertype};
      else if (acl_seen != {o_acl_dest_mac, o_acl_src_mac, o_acl_ethertype}) acl_unstable++;
      req_cycles++;
      req_run++;
    end else begin
      req_run = 0;
      sent    = 1'b0;
    end
    if (i_acl_valid) strobe_cycle = cycle;
    if (o_tx_tvalid && first_tv < 0) first_tv = cycle;
    if (prev_stall && o_tx_tvalid && (o_tx_tdata != prev_data)) viol++;
    prev_stall = o_tx_tvalid && !i_tx_tready;
    prev_data  = o_tx_tdata;
    if (o_tx_tvalid && i_tx_tready) begin
      out_q.push_back(o_tx_tdata);
      if (o_tx_tlast) begin
        tlast_cnt++;
        tlast_idx = out_q.size();
        if (tlast_cnt == 1) first_tlast_cycle = cycle;
      end
    end
    do_pop = o_fifo_rd;
    if (o_fifo_rd) begin
      pops++;
      if (i_fifo_empty) viol++;
      if (!i_tx_tready && first_tv >= 0) viol++;
      if (first_tlast_cycle >= 0 && first_pop_after < 0) first_pop_after = cycle;
    end
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    i_acl_valid  = 1'b0;
    i_acl_permit = 1'b0;
    if (obs_req && !sent && verdict_mode != 2 && req_run == verdict_delay) begin
      i_acl_valid  = 1'b1;
      i_acl_permit = (verdict_mode == 1);
      sent = 1'b1;
    end
    gap         = gap_en && ((cycle % 5) == 2);
    i_tx_tready = toggle_en ? ((cycle % 3) != 1) : 1'b1;
    drive_fifo();
  endtask

  task automatic run_until_quiet(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      step();
      n++;
      if (fifo_q.size() == 0 && !o_acl_req && !o_tx_tvalid) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check({name, "_cycle_budget"}, 128'(n), 128'(-1));
  endtask

  task automatic check_counters(input string name);
    check({name, "_fwd_count"},  128'(o_fwd_count),  128'(c_STATS ? exp_fwd : 0));
    check({name, "_drop_count"}, 128'(o_drop_count), 128'(c_STATS ? exp_drop : 0));
    check({name, "_runt_count"}, 128'(o_runt_count), 128'(c_STATS ? exp_runt : 0));
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{379, 1, 5, 1'b0, 1'b0, 379, 6, 1, 0, 0};
    tbl[1] = '{379, 0, 5, 1'b0, 1'b0,   0, 6, 0, 1, 0};
    tbl[2] = '{379, 2, 0, 1'b0, 1'b0,   0, 8, 0, 1, 0};
    tbl[3] = '{  3, 1, 1, 1'b0, 1'b0,   0, 0, 0, 0, 1};
    tbl[4] = '{ 20, 1, 2, 1'b1, 1'b1,  20, 3, 1, 0, 0};
    tbl[5] = '{  4, 1, 1, 1'b0, 1'b0,   4, 2, 1, 0, 0};
    tbl[6] = '{  4, 0, 3, 1'b0, 1'b0,   0, 4, 0, 1, 0};
    tbl[7] = '{  1, 1, 1, 1'b0, 1'b0,   0, 0, 0, 0, 1};
    tbl[8] = '{  5, 2, 0, 1'b0, 1'b0,   0, 8, 0, 1, 0};
    tbl[9] = '{  6, 1, 7, 1'b0, 1'b1,   6, 8, 1, 0, 0};

    rst_n = 1'b0; i_acl_valid = 1'b0; i_acl_permit = 1'b0; i_tx_tready = 1'b1;
    verdict_mode = 1; verdict_delay = 1; toggle_en = 1'b0; gap_en = 1'b0;
    clear_obs();
    push_frame(2, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd",  128'(o_fifo_rd), 128'(0));
    check("rst_acl_req",  128'(o_acl_req), 128'(0));
    check("rst_tx_ctrl",  128'({o_tx_tvalid, o_tx_tlast}), 128'(0));
    check("rst_tx_tdata", 128'(o_tx_tdata), 128'(0));
    check("rst_acl_fields", 128'({o_acl_dest_mac, o_acl_src_mac, o_acl_ethertype}), 128'(0));
    check_counters("rst");
    fifo_q.delete();
    drive_fifo();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int t = 0; t < 10; t++) begin
      string nm;
      int mism;
      nm = $sformatf("vec%0d", t);
      clear_obs();
      verdict_mode = tbl[t].verdict; verdict_delay = tbl[t].delay;
      toggle_en = tbl[t].toggle; gap_en = tbl[t].gaps;
      push_frame(tbl[t].nwords, t + 1);
      run_until_quiet(nm, 2000);
      exp_fwd += tbl[t].d_fwd; exp_drop += tbl[t].d_drop; exp_runt += tbl[t].d_runt;

      check({nm, "_pops"},       128'(pops),          128'(tbl[t].nwords));
      check({nm, "_out_words"},  128'(out_q.size()),  128'(tbl[t].exp_out));
      check({nm, "_req_cycles"}, 128'(req_cycles),    128'(tbl[t].exp_req));
      check({nm, "_protocol"},   128'(viol),          128'(0));
      if (tbl[t].exp_out > 0) begin
        mism = 0;
        for (int i = 0; i < out_q.size() && i < exp_w.size(); i++)
          if (out_q[i] != exp_w[i]) mism++;
        check({nm, "_out_data_mismatches"}, 128'(mism), 128'(0));
        check({nm, "_tlast_cnt_pos"}, 128'({tlast_cnt, tlast_idx}), 128'({1, tbl[t].exp_out}));
        check({nm, "_latency"}, 128'(first_tv - strobe_cycle), 128'(1));
      end else begin
        check({nm, "_tlast_cnt"}, 128'(tlast_cnt), 128'(0));
      end
      if (tbl[t].exp_req > 0) begin
        check({nm, "_acl_fields"}, 128'(acl_seen), 128'({c_DA, c_SA, c_TYPE}));
        check({nm, "_acl_stable"}, 128'(acl_unstable), 128'(0));
      end
      check_counters(nm);
    end

    // Back-to-back 4-word frames: next frame's HDR pop lands 2 cycles after tlast.
    clear_obs();
    verdict_mode = 1; verdict_delay = 1; toggle_en = 1'b0; gap_en = 1'b0;
    push_frame(4, 20);
    push_frame(4, 21);
    run_until_quiet("b2b", 500);
    exp_fwd += 2;
    check("b2b_out_words", 128'(out_q.size()), 128'(8));
    check("b2b_tlast_cnt", 128'(tlast_cnt), 128'(2));
    check("b2b_hdr_restart", 128'(first_pop_after - first_tlast_cycle), 128'(2));
    check("b2b_second_data", 128'(out_q.size() == 8 ? out_q[4] : 32'h0), 128'(c_DA[47:16]));
    check_counters("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
